systolic_skew_feeder: RTL and testbench

//  Upstream stage of the 4x4 PE matrix: accepts activation row-vectors over valid/ready,

---
 rtl/npu_pkg.sv | 22 ++
 rtl/skew_delay_line.sv | 44 ++++
 rtl/systolic_skew_feeder.sv | 150 +++++++++++++++
 tb/tb_systolic_skew_feeder.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/npu_pkg.sv
// rtl/npu_pkg.sv - shared types and sizes for the NPU feeder datapath
// Purpose: array dimension, element width, feeder FSM states and the lane
//          payload (data + enable) carried through the skew delay lines.
// Ports:   none (package).
package npu_pkg;

    localparam int NPU_N     = 4;
    localparam int NPU_WIDTH = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FEED  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } feeder_state_e;

    typedef struct packed {
        logic signed [NPU_WIDTH-1:0] data;
        logic                        en;
    } lane_t;

endpackage

// File: rtl/skew_delay_line.sv
// rtl/skew_delay_line.sv - DEPTH-stage shift register of lane payloads
// Purpose: delays one matrix lane by DEPTH cycles; stage 0 is registered,
//          so DEPTH=1 gives a single-cycle latency.
// Ports:   i_clk, i_rst (async, active-high), i_lane (payload in),
//          o_lane (payload DEPTH cycles later).
module skew_delay_line
    import npu_pkg::*;
#(
    parameter int DEPTH = 1,
    parameter int WIDTH = NPU_WIDTH
) (
    input  logic  i_clk,
    input  logic  i_rst,
    input  lane_t i_lane,
    output lane_t o_lane
);

    // The payload type is fixed by the package; a mismatched WIDTH would
    // silently truncate data, so refuse to elaborate instead.
    if (WIDTH != NPU_WIDTH) begin : g_bad_width
        $error("skew_delay_line: WIDTH must equal NPU_WIDTH");
    end
    if (DEPTH < 1) begin : g_bad_depth
        $error("skew_delay_line: DEPTH must be at least 1");
    end

    lane_t r_stage [DEPTH];

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int k = 0; k < DEPTH; k++) begin
                r_stage[k] <= '0;
            end
        end else begin
            r_stage[0] <= i_lane;
            for (int k = 1; k < DEPTH; k++) begin
                r_stage[k] <= r_stage[k-1];
            end
        end
    end

    assign o_lane = r_stage[DEPTH-1];

endmodule

// File: rtl/systolic_skew_feeder.sv
// rtl/systolic_skew_feeder.sv - diagonal skew feeder in front of the 4x4 PE matrix
// Purpose: accepts activation vectors over valid/ready, delays lane i by i
//          extra cycles, flushes zeros for 2N-1 cycles after the last vector,
//          then pulses o_done for one cycle.
// Ports:   i_clk, i_rst (async, active-high), i_start, i_num_vecs,
//          i_in_valid, i_in_data -> o_in_ready, o_out_left, o_out_en,
//          o_busy, o_done.
// Option:  FEEDER_PERF_CNT_EN adds o_stall_cycles and o_job_cycles.
module systolic_skew_feeder
    import npu_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int N     = 4,
    parameter int CNT_W = 16
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_start,
    input  logic [CNT_W-1:0]   i_num_vecs,
    input  logic               i_in_valid,
    input  logic [N*WIDTH-1:0] i_in_data,
    output logic               o_in_ready,
    output logic [N*WIDTH-1:0] o_out_left,
    output logic [N-1:0]       o_out_en,
    output logic               o_busy,
    output logic               o_done
`ifdef FEEDER_PERF_CNT_EN
    ,
    output logic [31:0]        o_stall_cycles,
    output logic [31:0]        o_job_cycles
`endif
);

    if (N != NPU_N || WIDTH != NPU_WIDTH) begin : g_bad_cfg
        $error("systolic_skew_feeder: only N=4, WIDTH=16 supported");
    end

    // Last drain count value; drain lasts DRAIN_LAST+1 = 2N-1 cycles, enough
    // for the deepest lane (N stages) to empty behind the final vector.
    localparam int DRAIN_LAST = 2 * N - 2;

    feeder_state_e    r_state;
    feeder_state_e    w_state_next;
    logic [CNT_W-1:0] r_num_vecs;
    logic [CNT_W-1:0] r_accepted;
    logic [2:0]       r_drain_cnt;
    logic             w_accept;
    logic             w_last_accept;
    lane_t            w_stage0 [N];
    lane_t            w_lane_out [N];

    assign o_in_ready    = (r_state == FEED);
    assign o_busy        = (r_state != IDLE);
    assign o_done        = (r_state == DONE);
    assign w_accept      = i_in_valid & o_in_ready;
    assign w_last_accept = w_accept && (r_accepted == r_num_vecs - CNT_W'(1));

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (i_start) begin
                    w_state_next = (i_num_vecs == '0) ? DONE : FEED;
                end
            end
            FEED: begin
                if (w_last_accept) begin
                    w_state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (r_drain_cnt == 3'(DRAIN_LAST)) begin
                    w_state_next = DONE;
                end
            end
            DONE:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_num_vecs  <= '0;
            r_accepted  <= '0;
            r_drain_cnt <= '0;
        end else begin
            if (r_state == IDLE && i_start) begin
                r_num_vecs <= i_num_vecs;
                r_accepted <= '0;
            end else if (w_accept) begin
                r_accepted <= r_accepted + CNT_W'(1);
            end
            r_drain_cnt <= (r_state == DRAIN) ? r_drain_cnt + 3'd1 : 3'd0;
        end
    end

    // Bubbles and drain cycles inject zero data with enable low, so the
    // matrix sees clean zeros rather than stale operands.
    for (genvar i = 0; i < N; i++) begin : g_lane
        assign w_stage0[i].data = w_accept ? i_in_data[i*WIDTH +: WIDTH] : '0;
        assign w_stage0[i].en   = w_accept;

        skew_delay_line #(
            .DEPTH (i + 1),
            .WIDTH (WIDTH)
        ) u_delay (
            .i_clk  (i_clk),
            .i_rst  (i_rst),
            .i_lane (w_stage0[i]),
            .o_lane (w_lane_out[i])
        );

        assign o_out_left[i*WIDTH +: WIDTH] = w_lane_out[i].data;
        assign o_out_en[i]                  = w_lane_out[i].en;
    end

`ifdef FEEDER_PERF_CNT_EN
    logic [31:0] r_stall_cycles;
    logic [31:0] r_job_cycles;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_stall_cycles <= '0;
            r_job_cycles   <= '0;
        end else if (r_state == IDLE && i_start) begin
            r_stall_cycles <= '0;
            r_job_cycles   <= '0;
        end else begin
            if (r_state == FEED && !i_in_valid) begin
                r_stall_cycles <= r_stall_cycles + 32'd1;
            end
            if (r_state != IDLE) begin
                r_job_cycles <= r_job_cycles + 32'd1;
            end
        end
    end

    assign o_stall_cycles = r_stall_cycles;
    assign o_job_cycles   = r_job_cycles;
`endif

endmodule

// File: tb/tb_systolic_skew_feeder.sv
// tb/tb_systolic_skew_feeder.sv - directed self-checking bench for systolic_skew_feeder
module tb_systolic_skew_feeder;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] num_vecs;
    logic        in_valid;
    logic [63:0] in_data;
    logic        in_ready;
    logic [63:0] out_left;
    logic [3:0]  out_en;
    logic        busy;
    logic        done;
`ifdef FEEDER_PERF_CNT_EN
    logic [31:0] stall_cycles;
    logic [31:0] job_cycles;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    systolic_skew_feeder #(.WIDTH(16), .N(4), .CNT_W(16)) dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_start        (start),
        .i_num_vecs     (num_vecs),
        .i_in_valid     (in_valid),
        .i_in_data      (in_data),
        .o_in_ready     (in_ready),
        .o_out_left     (out_left),
        .o_out_en       (out_en),
        .o_busy         (busy),
        .o_done         (done)
`ifdef FEEDER_PERF_CNT_EN
        ,
        .o_stall_cycles (stall_cycles),
        .o_job_cycles   (job_cycles)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] lane(input int i);
        return out_left[i*16 +: 16];
    endfunction

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 40) begin
            tick();
            n++;
        end
        chk("idle_reached", {63'd0, busy}, 64'd0);
    endtask

    initial begin
        int rdy;
        int dn;
        int dcyc;
        logic busy12;
        logic [3:0] en_tail [3];

        rst = 1'b1; start = 1'b0; num_vecs = '0; in_valid = 1'b0; in_data = '0;
        tick(); tick();
        chk("rst_busy",     {63'd0, busy},     64'd0);
        chk("rst_done",     {63'd0, done},     64'd0);
        chk("rst_in_ready", {63'd0, in_ready}, 64'd0);
        chk("rst_out_en",   {60'd0, out_en},   64'd0);
        chk("rst_out_left", out_left,          64'd0);
        rst = 1'b0;
        tick();

        // num_vecs == 0: straight to DONE, no in_ready
        start = 1'b1; num_vecs = 16'd0; in_valid = 1'b1; in_data = 64'h1111_2222_3333_4444;
        tick();
        chk("zero_done",     {63'd0, done},     64'd1);
        chk("zero_in_ready", {63'd0, in_ready}, 64'd0);
        start = 1'b0;
        tick();
        chk("zero_done_off", {63'd0, done},   64'd0);
        chk("zero_busy_off", {63'd0, busy},   64'd0);
        chk("zero_out_en",   {60'd0, out_en}, 64'd0);
        in_valid = 1'b0;

        // single vector: lane i appears i+1 cycles after accept
        start = 1'b1; num_vecs = 16'd1;
        tick();
        start = 1'b0;
        chk("one_in_ready", {63'd0, in_ready}, 64'd1);
        in_valid = 1'b1; in_data = 64'h0004_0003_0002_0001;
        tick();
        in_valid = 1'b0;
        chk("one_lane0", {48'd0, lane(0)}, 64'd1);
        chk("one_en0",   {60'd0, out_en},  64'h1);
        for (int i = 1; i < 4; i++) begin
            tick();
            chk($sformatf("one_lane%0d", i), {48'd0, lane(i)}, 64'(i + 1));
            chk($sformatf("one_en%0d", i),   {60'd0, out_en},  64'(1 << i));
        end
        wait_idle();

        // three vectors back to back: 3 ready cycles, done at cycle 11
        start = 1'b1; num_vecs = 16'd3; in_valid = 1'b1; in_data = 64'h0004_0003_0002_0001;
        tick();
        start = 1'b0;
        rdy = 0; dn = 0; dcyc = 0; busy12 = 1'b1;
        for (int c = 1; c <= 14; c++) begin
            if (in_ready) rdy++;
            if (done) begin dn++; dcyc = c; end
            if (c == 12) busy12 = busy;
            tick();
        end
        in_valid = 1'b0;
        chk("three_ready_cycles", 64'(rdy),           64'd3);
        chk("three_done_count",   64'(dn),            64'd1);
        chk("three_done_cycle",   64'(dcyc),          64'd11);
        chk("three_busy_after",   {63'd0, busy12},    64'd0);
`ifdef FEEDER_PERF_CNT_EN
        chk("three_job_cycles",   {32'd0, job_cycles},   64'd11);
        chk("three_stall_cycles", {32'd0, stall_cycles}, 64'd0);
`endif

        // two vectors with a 2-cycle gap: bubble visible skewed on every lane
        start = 1'b1; num_vecs = 16'd2;
        tick();
        start = 1'b0;
        in_valid = 1'b1; in_data = 64'h0008_0007_0006_0005;
        tick();
        chk("gap_en_e1", {60'd0, out_en}, 64'h1);
        in_valid = 1'b0;
        tick();
        chk("gap_en_e2",   {60'd0, out_en}, 64'h2);
        chk("gap_left_e2", out_left,        64'h0000_0000_0006_0000);
        tick();
        chk("gap_en_e3", {60'd0, out_en}, 64'h4);
        in_valid = 1'b1; in_data = 64'h000C_000B_000A_0009;
        tick();
        in_valid = 1'b0;
        chk("gap_en_e4",   {60'd0, out_en}, 64'h9);
        chk("gap_left_e4", out_left,        64'h0008_0000_0000_0009);
        en_tail[0] = 4'h2; en_tail[1] = 4'h4; en_tail[2] = 4'h8;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk($sformatf("gap_en_e%0d", k + 5), {60'd0, out_en}, {60'd0, en_tail[k]});
        end
        wait_idle();
`ifdef FEEDER_PERF_CNT_EN
        chk("gap_stall_cycles", {32'd0, stall_cycles}, 64'd2);
`endif

        // start during FEED is ignored; most-negative value passes bit-exact
        start = 1'b1; num_vecs = 16'd2;
        tick();
        num_vecs = 16'd5;
        in_valid = 1'b1; in_data = 64'h7FFF_FFFF_0001_8000;
        tick();
        chk("neg_left_e1", out_left, 64'h0000_0000_0000_8000);
        tick();
        chk("neg_left_e2",   out_left,              64'h0000_0000_0001_8000);
        chk("neg_in_ready",  {63'd0, in_ready},     64'd0);
        chk("neg_busy",      {63'd0, busy},         64'd1);
        start = 1'b0; in_valid = 1'b0;
        wait_idle();

        // reset mid-FEED with data in the delay lines
        start = 1'b1; num_vecs = 16'd4;
        tick();
        start = 1'b0;
        in_valid = 1'b1; in_data = 64'h0044_0033_0022_0011;
        tick(); tick();
        chk("pre_rst_en", {60'd0, out_en}, 64'h3);
        rst = 1'b1;
        #1;
        chk("mid_rst_out_en",   {60'd0, out_en}, 64'd0);
        chk("mid_rst_out_left", out_left,        64'd0);
        chk("mid_rst_busy",     {63'd0, busy},   64'd0);
        tick();
        rst = 1'b0;
        tick();
        chk("post_rst_in_ready", {63'd0, in_ready}, 64'd0);
        chk("post_rst_out_en",   {60'd0, out_en},   64'd0);
        in_valid = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
